fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Front end of the 16-bit CPU. Owns the program counter and sequences the
//  combinational instruction ROM (8-bit addr, 16-bit word {opc[3:0],rd[1:0],rs[1:0],imm[7:0]}).
//  Registers each fetched word toward decode with a valid/ready handshake.
//  Handles branch redirects and HLT, and optionally inserts hazard bubbles.
// PARAMETERS
//  ADDR_W    8        PC / ROM address width
//  INSTR_W   16       instruction width
//  RESET_PC  8'h00    PC loaded on reset and on run
//  WB_LAT    3        cycles from issue until a written register is readable
// PORTS
//  clk             in   1        system clock, rising edge
//  rst             in   1        asynchronous reset, active-high
//  run             in   1        pulse: start/restart fetch from RESET_PC
//  imem_addr       out  ADDR_W   ROM address (= pc)
//  imem_instr      in   INSTR_W  ROM data, same-cycle combinational
//  if_instr        out  INSTR_W  registered instruction to decode
//  if_pc           out  ADDR_W   address of if_instr
//  if_valid        out  1        if_instr holds a real or bubble word
//  id_ready        in   1        decode accepts if_instr this cycle
//  redirect_valid  in   1        branch/jump taken, 1-cycle pulse
//  redirect_pc     in   ADDR_W   branch target
//  halted          out  1        HLT issued; fetch stopped
//  busy            out  1        state == FETCH
// BEHAVIOUR
//  - Reset: state=IDLE, pc=RESET_PC, if_instr=16'h0000 (NOP), if_pc=0,
//    if_valid=0, halted=0, busy=0. Scoreboard cleared.
//  - States: IDLE -run-> FETCH; FETCH -HLT latched-> HALT; HALT -run-> FETCH.
//    run in FETCH restarts: pc=RESET_PC, if_valid=0 next cycle.
//  - Advance = (state==FETCH) && (!if_valid || id_ready). On advance:
//    if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=pc+1 (mod 2^ADDR_W, 8'hFF->8'h00).
//  - Stall: if_valid && !id_ready holds if_instr, if_pc, pc unchanged.
//  - Redirect (FETCH only, highest priority over advance/stall): pc<=redirect_pc,
//    if_valid<=0 next cycle (wrong-path word flushed). First target word at
//    if_instr two cycles after pulse. Ignored in IDLE and HALT.
//  - HLT (opc 4'b1111) latched: next state HALT, pc frozen at HLT addr+1;
//    HLT word stays valid until accepted, then if_valid=0; halted=1 from cycle
//    after latch. Redirect and HLT same cycle: redirect wins, HLT discarded.
//  - imem_addr = pc continuously; output changes only on clock edge.
//  - Fetch latency: ROM word at pc visible on if_instr 1 cycle after advance.
// CONFIGURATION
//  HAZARD_INTERLOCK_EN defined: per-register countdown (4 regs, WB_LAT wide);
//   on issuing a writer of rd, cnt[rd]<=WB_LAT; all nonzero counts decrement
//   each cycle. If the ROM word reads a register with cnt!=0, issue bubble
//   (if_instr=NOP, if_valid=1, pc held). Redirect clears the scoreboard.
//  Not defined: no interlock; software pads hazards with WB_LAT NOPs.
// STRUCTURE
//  Shared package cpu_isa_pkg: OPC_NOP=4'h0, OPC_LDI=4'h8, OPC_ST=4'hA,
//   OPC_HLT=4'hF, field slice positions, writes_rd()/reads_rs()/reads_rd() decode
//   functions, fetch state enum.
//  Sub-module hazard_scoreboard (only instantiated under HAZARD_INTERLOCK_EN).
// TESTING
//  1 rst high mid-fetch at pc=5 -> same cycle if_valid=0, pc=0, state IDLE.
//  2 run, id_ready=1, ROM 0..9 = LDI,NOP x3,LDI,NOP x3,ST,HLT -> if_pc 0..9
//    consecutive, halted=1 after HLT latched, imem_addr held at 10.
//  3 id_ready=0 for 3 cycles at if_pc=4 -> if_instr/if_pc/pc stable, no skip.
//  4 redirect_valid, redirect_pc=8'h20 at if_pc=3 -> word 4 flushed, next
//    valid if_pc=8'h20; redirect coincident with HLT -> no halt.
//  5 redirect_pc=8'hFF, all NOP ROM -> if_pc 0xFF then 0x00 (wrap).
//  6 HAZARD_INTERLOCK_EN, R1=LDI at 0, ST reading R1 at 1 -> 3 bubbles
//    (if_instr=0) then ST issued; without macro ST issues next cycle.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit CPU: opcodes, instruction field positions,
// register-usage decode helpers and the fetch-stage state encoding.
package cpu_isa_pkg;

  localparam logic [3:0] OPC_NOP = 4'h0;
  localparam logic [3:0] OPC_LDI = 4'h8;
  localparam logic [3:0] OPC_ST  = 4'hA;
  localparam logic [3:0] OPC_HLT = 4'hF;

  // Word layout: {opc[3:0], rd[1:0], rs[1:0], imm[7:0]}
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 10;
  localparam int unsigned RS_MSB  = 9;
  localparam int unsigned RS_LSB  = 8;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HALT  = 2'd2
  } fetch_state_e;

  // 1..7 are rd <= rd op rs ALU ops, 8 LDI, 9 LD rd <= mem[rs+imm], A ST mem[rs+imm] <= rd
  function automatic logic writes_rd(input logic [3:0] opc);
    return (opc >= 4'h1) && (opc <= 4'h9);
  endfunction

  function automatic logic reads_rs(input logic [3:0] opc);
    return ((opc >= 4'h1) && (opc <= 4'h7)) || (opc == 4'h9) || (opc == OPC_ST);
  endfunction

  function automatic logic reads_rd(input logic [3:0] opc);
    return ((opc >= 4'h1) && (opc <= 4'h7)) || (opc == OPC_ST);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: instruction ROM port, fetch-to-decode handshake and branch redirect.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               if_valid;
  logic               id_ready;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  modport master (
    output imem_addr, if_instr, if_pc, if_valid,
    input  imem_instr, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, if_instr, if_pc, if_valid,
    output imem_instr, id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register write-back countdown; flags a RAW hazard when the presented word
// reads a register whose write has not yet become visible.
module hazard_scoreboard
  import cpu_isa_pkg::*;
#(
  parameter int unsigned WB_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       issue_i,
  input  logic [3:0] opc_i,
  input  logic [1:0] rd_i,
  input  logic [1:0] rs_i,
  output logic       hazard_o
);
  localparam int unsigned CNT_W = $clog2(WB_LAT + 1);

  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_W'(1) : '0;
      if (issue_i && writes_rd(opc_i) && (rd_i == 2'(r))) begin
        cnt_d[r] = CNT_W'(WB_LAT);
      end
      if (clear_i) begin
        cnt_d[r] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hazard_o = (reads_rs(opc_i) && (cnt_q[rs_i] != '0))
                 || (reads_rd(opc_i) && (cnt_q[rd_i] != '0));

endmodule

// File: rtl/fetch_sequencer.sv
// CPU fetch front end: owns the PC, sequences the combinational ROM and registers
// each word toward decode. HAZARD_INTERLOCK_EN adds scoreboard-driven bubbles.
module fetch_sequencer
  import cpu_isa_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       WB_LAT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  fetch_sequencer_if.master bus,
  output logic              halted,
  output logic              busy
);

  if (WB_LAT == 0) begin : g_wb_lat_check
    $error("WB_LAT must be at least 1");
  end

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;

  logic       advance;
  logic       redirect;
  logic       hazard;
  logic [3:0] opc;

  assign opc      = bus.imem_instr[OPC_MSB:OPC_LSB];
  assign advance  = (state_q == FS_FETCH) && (!valid_q || bus.id_ready);
  assign redirect = (state_q == FS_FETCH) && bus.redirect_valid;

`ifdef HAZARD_INTERLOCK_EN
  logic sb_clear;
  logic sb_issue;

  assign sb_clear = run || redirect;
  assign sb_issue = advance && !sb_clear && !hazard;

  hazard_scoreboard #(.WB_LAT(WB_LAT)) u_hazard_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (sb_clear),
    .issue_i  (sb_issue),
    .opc_i    (opc),
    .rd_i     (bus.imem_instr[RD_MSB:RD_LSB]),
    .rs_i     (bus.imem_instr[RS_MSB:RS_LSB]),
    .hazard_o (hazard)
  );
`else
  assign hazard = 1'b0;
`endif

  // Priority: run restart, then redirect flush, then advance/bubble, else hold.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifpc_d  = ifpc_q;
    instr_d = instr_q;
    valid_d = valid_q;

    if (run) begin
      state_d = FS_FETCH;
      pc_d    = RESET_PC;
      valid_d = 1'b0;
    end else if (redirect) begin
      pc_d    = bus.redirect_pc;
      valid_d = 1'b0;
    end else if (advance) begin
      ifpc_d  = pc_q;
      valid_d = 1'b1;
      if (hazard) begin
        instr_d = '0;
      end else begin
        instr_d = bus.imem_instr;
        pc_d    = pc_q + ADDR_W'(1);
        if (opc == OPC_HLT) begin
          state_d = FS_HALT;
        end
      end
    end else if ((state_q == FS_HALT) && valid_q && bus.id_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      ifpc_q  <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifpc_q  <= ifpc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ifpc_q;
  assign bus.if_valid  = valid_q;
  assign halted        = (state_q == FS_HALT);
  assign busy          = (state_q == FS_FETCH);

endmodule
